channel_scan_sequencer: RTL
===========================

Name: channel_scan_sequencer

Overview:
Parametrised successor to the spectrogram extractor's fixed 16-channel readout FSM. On each `ovf` trigger it walks a configurable set of channels, holding each for `SLOT_LEN` clock cycles. For each channel it drives a channel `selection` index and a start-of-slot load strobe `sl_out`. After the last enabled channel it emits a one-cycle end-of-frame reset pulse. Adds a runtime channel-enable mask with skipping, busy/frame status, a frame counter and a sticky overrun flag.

Parameters:
- NUM_CH, 16: number of channels (RTC counts as channel 0); min 2.
- SLOT_LEN, 12: cycles per channel slot; min 2.
- FRAME_W, 8: frame counter width.
- Derived localparams:
  - CH_W = $clog2(NUM_CH).
  - CNT_W = $clog2(SLOT_LEN).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ovf  in  1  scan trigger, level-sampled in IDLE.
- ch_mask  in  NUM_CH  channel enable mask, bit i enables channel i; latched at scan start.
- clr_ovr  in  1  synchronous clear of `overrun`.
- selection  out  CH_W  index of the channel currently being read.
- sl_out  out  1  load strobe, high on the first cycle of each slot.
- slot_cnt  out  CNT_W  cycle position within the current slot.
- rst_out  out  1  one-cycle end-of-frame pulse.
- busy  out  1  high in SCAN and FLUSH.
- overrun  out  1  sticky: a trigger arrived while busy.
- frame_cnt  out  FRAME_W  number of completed frames, wrapping.

Behaviour:
- Reset (async, immediate): state=IDLE; every output and internal register is 0, including the latched mask.
- State IDLE:
  - Condition ovf=1 and ch_mask!=0: latch ch_mask into mask_q; selection = lowest set bit; slot_cnt=0; go to SCAN next cycle.
  - ovf=1 with ch_mask==0: ignored. Stay in IDLE; no overrun.
  - In IDLE: selection=0, sl_out=0.
- State SCAN:
  - sl_out = (slot_cnt==0). It is a combinational decode of registered state, so there is no extra latency.
  - slot_cnt increments each cycle.
  - When slot_cnt==SLOT_LEN-1: slot_cnt wraps to 0 and selection advances to the next set bit of mask_q above the current index.
  - If no higher bit is set, go to FLUSH and set selection=0.
  - Disabled channels cost zero cycles.
- State FLUSH (exactly one cycle): rst_out=1, frame_cnt increments (wraps mod 2^FRAME_W), then IDLE.
  - An ovf sampled in FLUSH does not start a scan; IDLE must see ovf.
- Scan duration: popcount(mask_q)*SLOT_LEN cycles of SCAN, plus 1 cycle of FLUSH.
- Overrun:
  - Set when ovf=1 in SCAN or FLUSH.
  - Cleared by clr_ovr=1.
  - Simultaneous set and clear: set wins.
- ch_mask changes during SCAN or FLUSH are ignored until the next start.
- busy = (state != IDLE), decoded from the state register.
- Unreachable or illegal state encodings recover to IDLE on the next cycle, with outputs as in IDLE.
- Widths:
  - selection is always < NUM_CH.
  - slot_cnt is always < SLOT_LEN.
  - No arithmetic overflow except the frame_cnt wrap.

Decomposition:
- Shared package spectro_pkg holds:
  - the state enum (IDLE, SCAN, FLUSH);
  - default constants NUM_CH_DEF=16, SLOT_LEN_DEF=12.
- One sub-module, ch_next_finder: combinational, parametrised by NUM_CH.
  - Inputs: mask and current index.
  - Outputs: next set index strictly above current, plus a `found` flag.
  - A first_mode input returns the lowest set bit.

Test Plan:
- Default params, ch_mask=16'hFFFF, one-cycle ovf at cycle 0:
  - busy cycles 1-193.
  - sl_out at cycles 1+12k for k=0..15; last at 181.
  - selection=k during cycles 1+12k..12+12k.
  - rst_out only at cycle 193; frame_cnt 0->1.
- ch_mask=16'h0005, ovf at cycle 0:
  - selection=0 for cycles 1-12, selection=2 for cycles 13-24.
  - sl_out at 1 and 13; rst_out at 25; channel 1 never selected.
- ch_mask=0, ovf held high 20 cycles: busy, sl_out and overrun stay 0.
- Overrun and mask latching:
  - ovf at cycles 0 and 30 → overrun=1 from cycle 31.
  - clr_ovr and ovf both at cycle 40 → overrun stays 1.
  - clr_ovr alone at 200 → overrun=0.
  - Change ch_mask to 16'h0001 at cycle 5 → the full 16-slot frame still completes.
- Reset mid-scan: reset asserted at cycle 50 for 2 cycles → all outputs 0 immediately. A fresh ovf restarts at channel 0 with slot_cnt=0.
- FRAME_W=2, NUM_CH=4, SLOT_LEN=3, mask=4'hF: 5 back-to-back frames, each with 13 busy cycles → frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/spectro_pkg.sv
// Shared definitions for the spectrogram channel readout sequencer.
package spectro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } scan_state_e;

  localparam int NUM_CH_DEF   = 16;
  localparam int SLOT_LEN_DEF = 12;

endpackage

// File: rtl/ch_next_finder.sv
// Finds the next enabled channel strictly above the current index, or the
// lowest enabled channel when first_mode is set.
module ch_next_finder #(
  parameter int NUM_CH = 16,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              first_mode,
  output logic [CH_W-1:0]   nxt,
  output logic              found
);

  // Descending scan so the lowest qualifying bit is the one that sticks.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first_mode || (i > int'(cur)))) begin
        nxt   = CH_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_scan_sequencer.sv
// Trigger-driven channel scan: walks enabled channels one SLOT_LEN slot each,
// then emits a one-cycle end-of-frame pulse.
module channel_scan_sequencer
  import spectro_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int SLOT_LEN = SLOT_LEN_DEF,
  parameter int FRAME_W  = 8,
  localparam int CH_W    = $clog2(NUM_CH),
  localparam int CNT_W   = $clog2(SLOT_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ovf,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic               clr_ovr,
  output logic [CH_W-1:0]    selection,
  output logic               sl_out,
  output logic [CNT_W-1:0]   slot_cnt,
  output logic               rst_out,
  output logic               busy,
  output logic               overrun,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SCAN  = SCAN;
  localparam logic [1:0] ST_FLUSH = FLUSH;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_LEN - 1);

  logic [1:0]         state_q;
  logic [NUM_CH-1:0]  mask_q;
  logic [CH_W-1:0]    sel_q;
  logic [CNT_W-1:0]   slot_q;
  logic [FRAME_W-1:0] frame_q;
  logic               ovr_q;

  logic               in_idle;
  logic               in_scan;
  logic               in_flush;
  logic [NUM_CH-1:0]  find_mask;
  logic [CH_W-1:0]    find_nxt;
  logic               find_found;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_scan  = (state_q == ST_SCAN);
  assign in_flush = (state_q == ST_FLUSH);

  // In IDLE the finder looks at the live mask to pick the first channel.
  assign find_mask = in_idle ? ch_mask : mask_q;

  ch_next_finder #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_finder (
    .mask       (find_mask),
    .cur        (sel_q),
    .first_mode (in_idle),
    .nxt        (find_nxt),
    .found      (find_found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
      slot_q  <= '0;
      frame_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if ((in_scan || in_flush) && ovf) begin
        ovr_q <= 1'b1;
      end else if (clr_ovr) begin
        ovr_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (ovf && (ch_mask != '0)) begin
            mask_q  <= ch_mask;
            sel_q   <= find_nxt;
            slot_q  <= '0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (slot_q == SLOT_LAST) begin
            slot_q <= '0;
            if (find_found) begin
              sel_q <= find_nxt;
            end else begin
              sel_q   <= '0;
              state_q <= ST_FLUSH;
            end
          end else begin
            slot_q <= slot_q + CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          frame_q <= frame_q + FRAME_W'(1);
          state_q <= ST_IDLE;
        end
        default: begin
          sel_q   <= '0;
          slot_q  <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only; anything but SCAN looks idle.
  assign selection = in_scan ? sel_q : '0;
  assign slot_cnt  = in_scan ? slot_q : '0;
  assign sl_out    = in_scan && (slot_q == '0);
  assign rst_out   = in_flush;
  assign busy      = in_scan || in_flush;
  assign overrun   = ovr_q;
  assign frame_cnt = frame_q;

endmodule
